// File: rtl/pipe_pkg.sv
// Shared MIPS pipeline constants: handler PC, exception codes and the
// per-cycle stage action used by the inter-stage register.
package pipe_pkg;

  localparam logic [31:0] EXC_HANDLER_PC = 32'h0000_4180;
  localparam int          EXC_W          = 5;

  // EXC_NONE and EXC_INT share encoding 0: an interrupt is taken through req.
  localparam logic [EXC_W-1:0] EXC_NONE    = 5'd0;
  localparam logic [EXC_W-1:0] EXC_INT     = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL    = 5'd4;
  localparam logic [EXC_W-1:0] EXC_ADES    = 5'd5;
  localparam logic [EXC_W-1:0] EXC_SYSCALL = 5'd8;
  localparam logic [EXC_W-1:0] EXC_RI      = 5'd10;
  localparam logic [EXC_W-1:0] EXC_OV      = 5'd12;

  typedef enum logic [2:0] {
    ACT_RESET,
    ACT_REQ,
    ACT_STALL,
    ACT_FLUSH,
    ACT_LOAD
  } stage_act_e;

  function automatic stage_act_e pick_act(input logic reset, input logic req,
                                          input logic stall, input logic flush);
    if (reset)      return ACT_RESET;
    else if (req)   return ACT_REQ;
    else if (stall) return ACT_STALL;
    else if (flush) return ACT_FLUSH;
    else            return ACT_LOAD;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; never wraps.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset || clr)
      q <= '0;
    else if (inc && (q != {W{1'b1}}))
      q <= q + 1'b1;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with exception redirect, stall and
// EPC-preserving flush, plus saturating stall/bubble counters.
module pipe_stage_reg #(
  parameter int          DATA_W = 128,
  parameter int          EXC_W  = pipe_pkg::EXC_W,
  parameter int          CNT_W  = 16,
  parameter logic [31:0] EXC_PC = pipe_pkg::EXC_HANDLER_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              stall,
  input  logic              flush,
  input  logic              cnt_clr,
  input  logic              valid_in,
  input  logic [31:0]       pc_in,
  input  logic [31:0]       instr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [EXC_W-1:0]  exc_in,
  input  logic              bd_in,
  output logic              valid_out,
  output logic [31:0]       pc_out,
  output logic [31:0]       instr_out,
  output logic [DATA_W-1:0] data_out,
  output logic [EXC_W-1:0]  exc_out,
  output logic              bd_out,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);
  import pipe_pkg::*;

  stage_act_e act;

  always_comb act = pick_act(reset, req, stall, flush);

  always_ff @(posedge clk) begin
    unique case (act)
      ACT_RESET: begin
        valid_out <= 1'b0;
        pc_out    <= '0;
        instr_out <= '0;
        data_out  <= '0;
        exc_out   <= '0;
        bd_out    <= 1'b0;
      end
      ACT_REQ: begin
        valid_out <= 1'b0;
        pc_out    <= EXC_PC;
        instr_out <= '0;
        data_out  <= '0;
        exc_out   <= '0;
        bd_out    <= 1'b0;
      end
      ACT_STALL: ; // hold everything
      ACT_FLUSH: begin
        // Bubble keeps PC and delay-slot flag so CP0 can still form EPC.
        valid_out <= 1'b0;
        pc_out    <= pc_in;
        instr_out <= '0;
        data_out  <= '0;
        exc_out   <= '0;
        bd_out    <= bd_in;
      end
      default: begin
        valid_out <= valid_in;
        pc_out    <= pc_in;
        instr_out <= instr_in;
        data_out  <= data_in;
        exc_out   <= exc_in;
        bd_out    <= bd_in;
      end
    endcase
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (act == ACT_STALL),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (act == ACT_FLUSH),
    .q     (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized + directed bench for pipe_stage_reg against a behavioural model.
module tb_pipe_stage_reg;
  localparam int DATA_W = 128;
  localparam int EXC_W  = 5;
  localparam int CNT_W  = 2;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk, reset, req, stall, flush, cnt_clr;
  logic              valid_in, bd_in;
  logic [31:0]       pc_in, instr_in;
  logic [DATA_W-1:0] data_in;
  logic [EXC_W-1:0]  exc_in;
  logic              valid_out, bd_out;
  logic [31:0]       pc_out, instr_out;
  logic [DATA_W-1:0] data_out;
  logic [EXC_W-1:0]  exc_out;
  logic [CNT_W-1:0]  stall_cnt, bubble_cnt;

  pipe_stage_reg #(.DATA_W(DATA_W), .EXC_W(EXC_W), .CNT_W(CNT_W),
                   .EXC_PC(32'h0000_4180)) dut (
    .clk(clk), .reset(reset), .req(req), .stall(stall), .flush(flush),
    .cnt_clr(cnt_clr), .valid_in(valid_in), .pc_in(pc_in), .instr_in(instr_in),
    .data_in(data_in), .exc_in(exc_in), .bd_in(bd_in), .valid_out(valid_out),
    .pc_out(pc_out), .instr_out(instr_out), .data_out(data_out),
    .exc_out(exc_out), .bd_out(bd_out), .stall_cnt(stall_cnt),
    .bubble_cnt(bubble_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  bit chk_en = 0;

  // Model state
  logic              m_valid, m_bd;
  logic [31:0]       m_pc, m_instr;
  logic [DATA_W-1:0] m_data;
  logic [EXC_W-1:0]  m_exc;
  int                m_sc, m_bc;

  task automatic model_step();
    if (reset) begin
      m_valid = 0; m_pc = 0; m_instr = 0; m_data = 0; m_exc = 0; m_bd = 0;
      m_sc = 0; m_bc = 0;
    end else begin
      if (req) begin
        m_valid = 0; m_pc = 32'h4180; m_instr = 0; m_data = 0; m_exc = 0; m_bd = 0;
      end else if (!stall) begin
        m_pc = pc_in; m_bd = bd_in;
        m_valid = flush ? 1'b0 : valid_in;
        m_instr = flush ? '0 : instr_in;
        m_data  = flush ? '0 : data_in;
        m_exc   = flush ? '0 : exc_in;
      end
      if (cnt_clr) begin
        m_sc = 0; m_bc = 0;
      end else if (!req) begin
        if (stall) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
        else if (flush) m_bc = (m_bc < CMAX) ? m_bc + 1 : CMAX;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // Every-cycle comparison of DUT against the model
  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if ({valid_out, pc_out, instr_out, data_out, exc_out, bd_out} !==
          {m_valid, m_pc, m_instr, m_data, m_exc, m_bd} ||
          stall_cnt !== CNT_W'(m_sc) || bubble_cnt !== CNT_W'(m_bc)) begin
        miscompares++;
        $display("FAIL model t=%0t got v=%b pc=%h i=%h d=%h e=%h bd=%b sc=%0d bc=%0d want v=%b pc=%h i=%h d=%h e=%h bd=%b sc=%0d bc=%0d",
                 $time, valid_out, pc_out, instr_out, data_out, exc_out, bd_out,
                 stall_cnt, bubble_cnt, m_valid, m_pc, m_instr, m_data, m_exc,
                 m_bd, m_sc, m_bc);
      end
    end
  end

  task automatic chk(input string nm, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    reset = 0; req = 0; stall = 0; flush = 0; cnt_clr = 0;
  endtask

  task automatic rand_in();
    valid_in = 1'($urandom); pc_in = $urandom; instr_in = $urandom;
    data_in = {$urandom, $urandom, $urandom, $urandom};
    exc_in = EXC_W'($urandom); bd_in = 1'($urandom);
  endtask

  initial begin
    idle(); rand_in();
    reset = 1;
    cycle(); cycle();
    chk_en = 1;
    chk("rst_valid", DATA_W'(valid_out), 0);
    chk("rst_pc", DATA_W'(pc_out), 0);
    chk("rst_cnt", DATA_W'({stall_cnt, bubble_cnt}), 0);

    // Load
    idle(); pc_in = 32'h3000; instr_in = 32'h2401_0001; valid_in = 1;
    cycle();
    chk("load_pc", DATA_W'(pc_out), 32'h3000);
    chk("load_instr", DATA_W'(instr_out), 32'h2401_0001);
    chk("load_valid", DATA_W'(valid_out), 1);

    // Stall with concurrent flush, changing inputs
    stall = 1; flush = 1;
    for (int i = 0; i < 3; i++) begin rand_in(); cycle(); end
    chk("stall_pc", DATA_W'(pc_out), 32'h3000);
    chk("stall_instr", DATA_W'(instr_out), 32'h2401_0001);
    chk("stall_cnt3", DATA_W'(stall_cnt), 3);
    chk("stall_bub0", DATA_W'(bubble_cnt), 0);

    // Flush retains PC and bd
    idle(); flush = 1; pc_in = 32'h3008; bd_in = 1; exc_in = 4; valid_in = 1;
    cycle();
    chk("flush_pc", DATA_W'(pc_out), 32'h3008);
    chk("flush_bd", DATA_W'(bd_out), 1);
    chk("flush_instr", DATA_W'(instr_out), 0);
    chk("flush_exc", DATA_W'(exc_out), 0);
    chk("flush_valid", DATA_W'(valid_out), 0);
    chk("flush_bub", DATA_W'(bubble_cnt), 1);

    // Exception overrides stall
    idle(); req = 1; stall = 1; rand_in();
    cycle();
    chk("req_pc", DATA_W'(pc_out), 32'h4180);
    chk("req_zero", DATA_W'({valid_out, instr_out, exc_out, bd_out}), 0);
    chk("req_data", data_out, 0);
    chk("req_cnt", DATA_W'({stall_cnt, bubble_cnt}), 4'b11_01);

    // Saturation and clear-with-stall
    idle(); cnt_clr = 1; cycle();
    chk("clr_cnt", DATA_W'({stall_cnt, bubble_cnt}), 0);
    idle(); stall = 1;
    for (int i = 0; i < 5; i++) cycle();
    chk("sat_cnt", DATA_W'(stall_cnt), 3);
    cnt_clr = 1; cycle();
    chk("clr_stall", DATA_W'(stall_cnt), 0);

    // Reset mid-operation, and reset with req
    idle(); rand_in(); valid_in = 1; cycle();
    stall = 1; cycle();
    chk("pre_rst_valid", DATA_W'(valid_out), 1);
    idle(); reset = 1; stall = 1; cycle();
    chk("mid_rst_all", DATA_W'({valid_out, pc_out, instr_out, exc_out, bd_out, stall_cnt}), 0);
    req = 1; cycle();
    chk("rst_req_pc", DATA_W'(pc_out), 0);
    idle(); rand_in(); cycle();
    chk("post_rst_load", DATA_W'(pc_out), DATA_W'(pc_in));

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rand_in();
      reset   = ($urandom_range(99) < 2);
      req     = ($urandom_range(99) < 6);
      stall   = ($urandom_range(99) < 35);
      flush   = ($urandom_range(99) < 30);
      cnt_clr = ($urandom_range(99) < 8);
      cycle();
    end

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
